// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the ADC capture FIFO read side.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  localparam int unsigned SKID_DEPTH   = 2;
  localparam int unsigned SKID_LVL_W   = $clog2(SKID_DEPTH + 1);
  // FIFO words the pack/skid path can absorb without dropping anything
  localparam int unsigned CREDIT_LIMIT = 2 * SKID_DEPTH;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI4-Stream output stage; tvalid is derived from registered occupancy only.
module axis_skid_buffer
  import fifo_rd_pkg::*;
#(
  parameter int unsigned W = 33
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_s_valid,
  input  logic [W-1:0]          i_s_data,
  output logic                  o_m_valid,
  output logic [W-1:0]          o_m_data,
  input  logic                  i_m_ready,
  output logic [SKID_LVL_W-1:0] o_level
);

  logic [W-1:0]          r_head;
  logic [W-1:0]          r_tail;
  logic [SKID_LVL_W-1:0] r_cnt;
  logic                  w_push;
  logic                  w_pop;

  // Upstream credit accounting guarantees space whenever a beat is offered.
  assign w_push = i_s_valid & (r_cnt != SKID_LVL_W'(SKID_DEPTH));
  assign w_pop  = (r_cnt != '0) & i_m_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == '0) r_head <= i_s_data;
          else             r_tail <= i_s_data;
          r_cnt <= r_cnt + SKID_LVL_W'(1);
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - SKID_LVL_W'(1);
        end
        2'b11: begin
          if (r_cnt == SKID_LVL_W'(1)) begin
            r_head <= i_s_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_s_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_m_valid = (r_cnt != '0);
  assign o_m_data  = r_head;
  assign o_level   = r_cnt;

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains one frame of DATA_W words from the capture FIFO and packs word pairs
// into AXI4-Stream beats, with frame counting and underrun detection.
module fifo_frame_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FRAME_WORDS = 1024,
  parameter int unsigned TIMEOUT     = 4096,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk_100m,
  input  logic                rstn_i,
  input  logic                frame_rdy,
  input  logic [DATA_W-1:0]   fifo_dout,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  output logic [2*DATA_W-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                busy,
  output logic                frame_done,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic                err_underrun
);

  localparam int unsigned RW    = $clog2(FRAME_WORDS + 1);
  localparam int unsigned EW    = $clog2(TIMEOUT + 1);
  localparam int unsigned OUT_W = 2 * DATA_W;

  rd_state_e             r_state;
  rd_state_e             w_next;
  logic [RW-1:0]         r_rd_issued;
  logic [RW-1:0]         r_pack_cnt;
  logic                  r_rd_vld;
  logic                  r_half;
  logic [DATA_W-1:0]     r_lo;
  logic [EW-1:0]         r_empty_cnt;
  logic                  r_err;
  logic [CNT_W-1:0]      r_frame_cnt;

  logic [SKID_LVL_W-1:0] w_skid_lvl;
  logic [OUT_W:0]        w_skid_out;
  logic [OUT_W:0]        w_beat;
  logic [3:0]            w_held;
  logic                  w_credit_ok;
  logic                  w_rd_en;
  logic                  w_abort;
  logic                  w_beat_valid;
  logic                  w_last_acc;

  // Words in flight plus words parked in the pack register and skid entries.
  assign w_held       = 4'(r_rd_vld) + 4'(r_half) + (4'(w_skid_lvl) << 1);
  assign w_credit_ok  = (w_held <= 4'(CREDIT_LIMIT - 1));
  assign w_rd_en      = (r_state == READ) & ~fifo_empty &
                        (r_rd_issued < RW'(FRAME_WORDS)) & w_credit_ok;
  assign w_abort      = (r_state == READ) & fifo_empty &
                        (r_rd_issued != RW'(FRAME_WORDS)) &
                        (r_empty_cnt == EW'(TIMEOUT - 1));
  assign w_beat_valid = r_rd_vld & r_half;
  assign w_beat       = {(r_pack_cnt == RW'(FRAME_WORDS - 1)), fifo_dout, r_lo};
  assign w_last_acc   = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_ff @(posedge clk_100m) begin
    if (rstn_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (frame_rdy && !r_err) w_next = READ;
      READ: begin
        if (r_rd_issued == RW'(FRAME_WORDS)) w_next = DRAIN;
        else if (w_abort)                    w_next = IDLE;
      end
      DRAIN:   if (w_last_acc) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = w_rd_en;
    busy       = (r_state != IDLE);
    frame_done = (r_state == DONE);
  end

  always_ff @(posedge clk_100m) begin
    if (rstn_i) begin
      r_rd_issued <= '0;
      r_pack_cnt  <= '0;
      r_rd_vld    <= 1'b0;
      r_half      <= 1'b0;
      r_lo        <= '0;
      r_empty_cnt <= '0;
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_rd_vld <= w_rd_en;

      if (r_state == IDLE) r_rd_issued <= '0;
      else if (w_rd_en)    r_rd_issued <= r_rd_issued + RW'(1);

      if (r_state == IDLE || w_abort) begin
        r_pack_cnt <= '0;
        r_half     <= 1'b0;
      end else if (r_rd_vld) begin
        r_pack_cnt <= r_pack_cnt + RW'(1);
        r_half     <= ~r_half;
        if (!r_half) r_lo <= fifo_dout;
      end

      if (r_state != READ || w_rd_en) r_empty_cnt <= '0;
      else if (fifo_empty)            r_empty_cnt <= r_empty_cnt + EW'(1);

      if (w_abort)           r_err       <= 1'b1;
      if (r_state == DONE)   r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

  axis_skid_buffer #(
    .W (OUT_W + 1)
  ) u_skid (
    .i_clk     (clk_100m),
    .i_rst     (rstn_i),
    .i_flush   (w_abort),
    .i_s_valid (w_beat_valid),
    .i_s_data  (w_beat),
    .o_m_valid (m_axis_tvalid),
    .o_m_data  (w_skid_out),
    .i_m_ready (m_axis_tready),
    .o_level   (w_skid_lvl)
  );

  assign m_axis_tlast = w_skid_out[OUT_W];
  assign m_axis_tdata = w_skid_out[OUT_W-1:0];
  assign frame_cnt    = r_frame_cnt;
  assign err_underrun = r_err;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Self-checking bench for fifo_frame_reader: FIFO model, frame-level beat model, directed scenarios.
module tb_fifo_frame_reader;

  localparam int CNT_MOD = 4;

  logic        clk_100m;
  logic        rstn_i;
  logic        frame_rdy;
  logic [15:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic        frame_done;
  logic [1:0]  frame_cnt;
  logic        err_underrun;

  fifo_frame_reader #(
    .DATA_W      (16),
    .FRAME_WORDS (8),
    .TIMEOUT     (16),
    .CNT_W       (2)
  ) dut (
    .clk_100m      (clk_100m),
    .rstn_i        (rstn_i),
    .frame_rdy     (frame_rdy),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt),
    .err_underrun  (err_underrun)
  );

  initial clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;

  // Standard-mode FIFO: data appears one cycle after the read strobe.
  logic [15:0] mem [0:63];
  int          wp = 0;
  int          rp = 0;
  logic        fifo_clr = 1'b0;
  assign fifo_empty = (rp == wp);
  initial fifo_dout = '0;
  always @(posedge clk_100m) begin
    if (fifo_clr) rp <= 0;
    else if (fifo_rd_en && rp < wp) begin
      fifo_dout <= mem[rp];
      rp        <= rp + 1;
    end
  end

  int          vectors = 0;
  int          miscompares = 0;
  logic [32:0] expq[$];
  logic [32:0] gotq[$];
  logic [32:0] prev_beat;
  logic        prev_stall;
  logic        done_due;
  int          exp_cnt;
  int          reads;
  int          acc;
  logic        bp_mode = 1'b0;
  int          first_lat;
  int          gap_max;
  int          cnt_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic        hs;
    logic [32:0] beat;
    beat = {m_axis_tlast, m_axis_tdata};
    hs   = m_axis_tvalid & m_axis_tready;
    if (prev_stall) begin
      chk("hold_valid", m_axis_tvalid, 1);
      chk("hold_beat", beat, prev_beat);
    end
    chk("rd_on_empty", fifo_rd_en & fifo_empty, 0);
    if (fifo_rd_en) begin
      chk("credit", (reads - 2 * acc) <= 3, 1);
      reads++;
    end
    if (hs) begin
      chk("beat_expected", expq.size() != 0, 1);
      if (expq.size() != 0) chk("beat", beat, expq.pop_front());
      gotq.push_back(beat);
      acc++;
    end
    chk("frame_done", frame_done, done_due);
    chk("frame_cnt", frame_cnt, exp_cnt % CNT_MOD);
    if (done_due) exp_cnt = (exp_cnt + 1) % CNT_MOD;
    done_due   = hs & m_axis_tlast;
    prev_stall = m_axis_tvalid & ~m_axis_tready;
    prev_beat  = beat;
  endtask

  task automatic tick();
    @(posedge clk_100m);
    #1;
    m_axis_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    check_cycle();
  endtask

  task automatic model_clear();
    expq.delete();
    gotq.delete();
    prev_stall = 1'b0;
    prev_beat  = '0;
    done_due   = 1'b0;
    exp_cnt    = 0;
    reads      = 0;
    acc        = 0;
  endtask

  task automatic reset_all();
    model_clear();
    rstn_i    = 1'b1;
    frame_rdy = 1'b0;
    fifo_clr  = 1'b1;
    tick();
    tick();
    fifo_clr = 1'b0;
    wp       = 0;
    rstn_i   = 1'b0;
  endtask

  task automatic load_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wp] = 16'(base + i);
      wp++;
    end
  endtask

  // One frame = four beats {hi word, lo word}, tlast on the fourth.
  task automatic expect_frame(input int base);
    logic [15:0] lo, hi;
    for (int p = 0; p < 4; p++) begin
      lo = 16'(base + 2 * p);
      hi = 16'(base + 2 * p + 1);
      expq.push_back({(p == 3), hi, lo});
    end
  endtask

  task automatic run_frames(input int n, input int budget);
    int   done_n, cyc, gap;
    logic log_next;
    done_n = 0; cyc = 0; gap = 0; log_next = 1'b0;
    first_lat = -1; gap_max = 0; cnt_log.delete();
    frame_rdy = 1'b1;
    while (done_n < n && cyc < budget) begin
      tick();
      cyc++;
      if (log_next) cnt_log.push_back(int'(frame_cnt));
      log_next = frame_done;
      if (m_axis_tvalid && first_lat < 0) first_lat = cyc;
      if (!busy) gap++;
      else begin
        if (done_n > 0 && gap > gap_max) gap_max = gap;
        gap = 0;
      end
      if (frame_done) done_n++;
      if (busy && !frame_done && done_n == n - 1) frame_rdy = 1'b0;
    end
    chk("frames_completed", done_n, n);
    tick();
    if (log_next) cnt_log.push_back(int'(frame_cnt));
  endtask

  task automatic check_basic_beats();
    chk("beats_n", gotq.size(), 4);
    if (gotq.size() >= 4) begin
      chk("beat0", gotq[0], 33'h0_0002_0001);
      chk("beat1", gotq[1], 33'h0_0004_0003);
      chk("beat2", gotq[2], 33'h0_0006_0005);
      chk("beat3", gotq[3], 33'h1_0008_0007);
    end
  endtask

  initial begin
    int   n_empty, r0, cyc;
    logic any_busy;
    int   exp_seq[5];
    exp_seq = '{1, 2, 3, 0, 1};
    rstn_i = 1'b1; frame_rdy = 1'b0; m_axis_tready = 1'b1;

    // Reset state
    reset_all();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_err", err_underrun, 0);

    // Basic frame
    reset_all();
    load_words(1, 8);
    expect_frame(1);
    chk("model_beat0", expq[0], 33'h0_0002_0001);
    chk("model_beat3", expq[3], 33'h1_0008_0007);
    run_frames(1, 200);
    chk("first_beat_latency", first_lat, 4);
    check_basic_beats();
    chk("basic_frame_cnt", frame_cnt, 1);
    chk("basic_busy_end", busy, 0);
    chk("basic_exp_left", expq.size(), 0);

    // Backpressure
    reset_all();
    load_words(1, 8);
    expect_frame(1);
    bp_mode = 1'b1;
    run_frames(1, 400);
    bp_mode = 1'b0;
    check_basic_beats();
    chk("bp_frame_cnt", frame_cnt, 1);

    // Back-to-back frames
    reset_all();
    load_words(1, 16);
    expect_frame(1);
    expect_frame(9);
    run_frames(2, 400);
    chk("b2b_beats_n", gotq.size(), 8);
    if (gotq.size() >= 8) begin
      chk("b2b_last3", gotq[3][32], 1);
      chk("b2b_beat4", gotq[4], 33'h0_000A_0009);
      chk("b2b_last7", gotq[7], 33'h1_0010_000F);
    end
    chk("b2b_idle_gap", gap_max, 1);
    chk("b2b_frame_cnt", frame_cnt, 2);

    // Underrun: five words only
    reset_all();
    load_words(1, 5);
    expq.push_back(33'h0_0002_0001);
    expq.push_back(33'h0_0004_0003);
    frame_rdy = 1'b1;
    n_empty = 0; cyc = 0;
    while (!err_underrun && cyc < 100) begin
      tick();
      cyc++;
      frame_rdy = 1'b0;
      if (busy && fifo_empty && !err_underrun) n_empty++;
    end
    chk("underrun_flag", err_underrun, 1);
    chk("underrun_empty_cycles", n_empty, 16);
    chk("underrun_tvalid", m_axis_tvalid, 0);
    chk("underrun_busy", busy, 0);
    chk("underrun_frame_cnt", frame_cnt, 0);
    chk("underrun_beats", gotq.size(), 2);
    load_words(100, 8);
    r0 = reads; any_busy = 1'b0;
    frame_rdy = 1'b1;
    repeat (10) begin
      tick();
      any_busy |= busy;
    end
    frame_rdy = 1'b0;
    chk("locked_busy", any_busy, 0);
    chk("locked_reads", reads - r0, 0);
    chk("locked_err", err_underrun, 1);

    // Mid-frame reset
    reset_all();
    load_words(1, 8);
    expect_frame(1);
    frame_rdy = 1'b1;
    cyc = 0;
    while (gotq.size() < 2 && cyc < 100) begin
      tick();
      cyc++;
      frame_rdy = 1'b0;
    end
    chk("midrst_two_beats", gotq.size(), 2);
    model_clear();
    rstn_i = 1'b1;
    tick();
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_tlast", m_axis_tlast, 0);
    chk("midrst_tdata", m_axis_tdata, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_en", fifo_rd_en, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_err", err_underrun, 0);
    rstn_i = 1'b0;
    reset_all();
    load_words(1, 8);
    expect_frame(1);
    run_frames(1, 200);
    chk("midrst_latency", first_lat, 4);
    check_basic_beats();
    chk("midrst_frame_cnt", frame_cnt, 1);

    // Counter wrap with 2-bit frame_cnt
    reset_all();
    load_words(1, 40);
    for (int f = 0; f < 5; f++) expect_frame(1 + 8 * f);
    run_frames(5, 600);
    chk("wrap_log_n", cnt_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < cnt_log.size()) chk("wrap_cnt", cnt_log[i], exp_seq[i]);
    chk("wrap_beats_n", gotq.size(), 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
